tile_lane_engine: RTL and testbench
===================================

Name: tile_lane_engine

Overview:
- Parametrised game core for the tile game: holds the falling-tile field, takes in scroll steps and lane key presses, and maintains score, lives and game state.
- Generalises the fixed 4-lane, 7-line shift/score path to LANES lanes and ROWS rows.
- Adds pseudo-random tile generation, wrong-key detection, a lives budget and a game-over state.
- Sits between the control FSM (step pulses) and the drawer (row outputs) and scoreboard.

Parameters:
- LANES, 4, number of key lanes (2..8)
- ROWS, 7, visible rows; row 0 is the top, row ROWS-1 is the hit row
- LIVES, 3, errors tolerated before game over (1..15)
- SCORE_W, 16, score counter width
- SEED, 16'hACE1, LFSR reset value (must be nonzero)
- LANE_W, $clog2(LANES), derived; width of a lane index

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a new game from IDLE or OVER
- step  in  1  one-cycle pulse; scroll the field down by one row
- keys  in  LANES  level key inputs, one per lane
- rows_valid  out  ROWS  bit r = 1: row r holds a tile
- rows_lane  out  ROWS*LANE_W  lane of row r, at bits [r*LANE_W +: LANE_W]
- score  out  SCORE_W  correct hits this game
- lives_left  out  4  remaining lives
- state  out  2  00 IDLE, 01 RUN, 10 OVER
- game_over  out  1  high while state is OVER
- hit_pulse  out  1  one-cycle pulse on a correct hit
- miss_pulse  out  1  one-cycle pulse on a wrong key or a missed tile

Behaviour:
- Reset:
  - state=IDLE; rows_valid=0; rows_lane=0; score=0; lives_left=LIVES.
  - Pulses low; LFSR=SEED; key-edge register=0.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every clock in every state; not cleared by start.
  - New-tile lane = lfsr[7:0] % LANES.
- Key edges:
  - press = keys & ~keys_q, where keys_q is keys registered every cycle.
  - A press event is any nonzero press.
- IDLE: step and keys are ignored; start goes to RUN.
- On start (IDLE or OVER):
  - Next cycle: rows_valid=0, score=0, lives_left=LIVES, state=RUN.
  - The field fills from the top with subsequent steps.
- RUN, step:
  - row[r] <= row[r-1] for r=1..ROWS-1.
  - row[0] <= {valid=1, lane=new-tile lane}.
  - If the old bottom row was valid and unhit, miss_pulse fires and lives decrement; that tile is discarded.
- RUN, press event, evaluated against the bottom row before any same-cycle shift:
  - Correct hit: bottom valid and press == one-hot(bottom lane). Clear bottom valid, score+1, hit_pulse.
  - Otherwise (bottom empty, wrong lane, or more than one new key bit): miss_pulse, lives decrement. Rows unchanged apart from any step.
- Simultaneous press and step, same cycle:
  - A correct hit consumes the bottom tile, so the step produces no miss for it.
  - A wrong press plus a step on an unhit valid bottom row costs two lives. Decrement saturates at 0; miss_pulse is a single pulse.
- Score: saturates at 2^SCORE_W-1; hit_pulse still fires at saturation.
- OVER:
  - Entered the cycle after lives_left reaches 0; rows freeze.
  - step and keys are ignored; only start leaves OVER.
- Latency: every output updates on the clock edge after the causing input; no output path is combinational from inputs.
- Reset mid-game returns to the full reset state within one cycle.

Decomposition:
- Package tile_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_OVER
  - LFSR tap mask and width
  - the row-entry typedef {valid, lane}
- One sub-module, tile_lfsr (16-bit, SEED parameter, free-running), instantiated once.

Test Plan:
- Reset then idle, with step and keys toggled -> rows_valid=0, score=0, lives_left=3, state=00 throughout.
- start, then 7 steps with no keys -> rows_valid=7'h7F after step 7, no miss_pulse; step 8 -> miss_pulse, lives_left=2.
- Field full, bottom lane=2, keys 0000->0100 -> hit_pulse, score=1, bottom valid cleared; holding keys high gives no further event.
- Bottom lane=1, press lane 3 -> miss_pulse, lives 3->2; press lanes 1 and 3 together -> miss, lives=1.
- Correct press and step in the same cycle -> score+1, no life lost. Wrong press and step with an unhit bottom at lives=2 -> lives=0, OVER next cycle, then step ignored; start -> RUN, score=0, lives=3.
- SCORE_W=3, 9 correct hits -> score holds at 7; LANES=3 -> every rows_lane entry < 3 over 200 steps.

Source files
------------

// File: rtl/tile_pkg.sv
// Shared state encoding, LFSR constants and row-entry type for the tile lane engine.
package tile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } state_e;

  localparam int LFSR_W = 16;
  // Taps 16,14,13,11 expressed as bit positions 0,2,3,5 of a right-shifting register.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

  // Wide enough for the largest supported lane count (8).
  localparam int LANE_MAX_W = 3;

  typedef struct packed {
    logic                  valid;
    logic [LANE_MAX_W-1:0] lane;
  } row_t;

  function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] value);
    return ^(value & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/tile_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; exposes its low byte for tile lane selection.
module tile_lfsr
  import tile_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] rand_byte
);

  logic [LFSR_W-1:0] lfsr_r;

  // Shift right every cycle, feedback enters at the top bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_r <= SEED;
    end else begin
      lfsr_r <= {lfsr_feedback(lfsr_r), lfsr_r[LFSR_W-1:1]};
    end
  end

  assign rand_byte = lfsr_r[7:0];

endmodule

// File: rtl/tile_lane_engine.sv
// Tile game core: scrolling tile field, key-press judging, score, lives and game state.
module tile_lane_engine
  import tile_pkg::*;
#(
  parameter int          LANES   = 4,
  parameter int          ROWS    = 7,
  parameter int          LIVES   = 3,
  parameter int          SCORE_W = 16,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          LANE_W  = $clog2(LANES)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     step,
  input  logic [LANES-1:0]         keys,
  output logic [ROWS-1:0]          rows_valid,
  output logic [ROWS*LANE_W-1:0]   rows_lane,
  output logic [SCORE_W-1:0]       score,
  output logic [3:0]               lives_left,
  output logic [1:0]               state,
  output logic                     game_over,
  output logic                     hit_pulse,
  output logic                     miss_pulse
);

  state_e                state_r, state_s;
  row_t                  row_r [ROWS];
  row_t                  row_s [ROWS];
  logic [SCORE_W-1:0]    score_r, score_s;
  logic [3:0]            lives_r, lives_s;
  logic [LANES-1:0]      keys_q_r;
  logic [LANES-1:0]      press_s;
  logic [LANES-1:0]      bottom_oh_s;
  logic                  hit_r, hit_s;
  logic                  miss_r, miss_s;
  logic                  consumed_s;
  logic [1:0]            errs_s;
  logic [7:0]            rand_byte_s;
  logic [LANE_MAX_W-1:0] new_lane_s;

  tile_lfsr #(.SEED(SEED)) u_lfsr (
    .clock     (clock),
    .reset     (reset),
    .rand_byte (rand_byte_s)
  );

  assign new_lane_s  = LANE_MAX_W'(rand_byte_s % 8'(LANES));
  assign bottom_oh_s = {{(LANES-1){1'b0}}, 1'b1} << row_r[ROWS-1].lane;

  // Next-state logic: start handling, key judging against the pre-shift bottom row, scrolling.
  always_comb begin
    state_s    = state_r;
    row_s      = row_r;
    score_s    = score_r;
    lives_s    = lives_r;
    hit_s      = 1'b0;
    miss_s     = 1'b0;
    consumed_s = 1'b0;
    errs_s     = 2'd0;
    press_s    = keys & ~keys_q_r;
    case (state_r)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_s = ST_RUN;
          for (int r = 0; r < ROWS; r++) begin
            row_s[r] = '0;
          end
          score_s = {SCORE_W{1'b0}};
          lives_s = 4'(LIVES);
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (lives_r == 4'd0) begin
          // Last life went on the previous edge; freeze from here on.
          state_s = ST_OVER;
        end else begin
          if (press_s != {LANES{1'b0}}) begin
            if (row_r[ROWS-1].valid && (press_s == bottom_oh_s)) begin
              hit_s                = 1'b1;
              consumed_s           = 1'b1;
              row_s[ROWS-1].valid  = 1'b0;
              if (score_r != {SCORE_W{1'b1}}) begin
                score_s = score_r + {{(SCORE_W-1){1'b0}}, 1'b1};
              end else begin
                score_s = score_r;
              end
            end else begin
              errs_s = 2'd1;
            end
          end else begin
            consumed_s = 1'b0;
          end
          if (step) begin
            if (row_r[ROWS-1].valid && !consumed_s) begin
              errs_s = errs_s + 2'd1;
            end else begin
              errs_s = errs_s;
            end
            for (int r = ROWS-1; r >= 1; r--) begin
              row_s[r] = row_r[r-1];
            end
            row_s[0].valid = 1'b1;
            row_s[0].lane  = new_lane_s;
          end else begin
            row_s[0] = row_s[0];
          end
          if (errs_s != 2'd0) begin
            miss_s = 1'b1;
            if ({2'b00, errs_s} >= lives_r) begin
              lives_s = 4'd0;
            end else begin
              lives_s = lives_r - {2'b00, errs_s};
            end
          end else begin
            lives_s = lives_r;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, field, counters, key history and event pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      for (int r = 0; r < ROWS; r++) begin
        row_r[r] <= '0;
      end
      score_r  <= {SCORE_W{1'b0}};
      lives_r  <= 4'(LIVES);
      keys_q_r <= {LANES{1'b0}};
      hit_r    <= 1'b0;
      miss_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      row_r    <= row_s;
      score_r  <= score_s;
      lives_r  <= lives_s;
      keys_q_r <= keys;
      hit_r    <= hit_s;
      miss_r   <= miss_s;
    end
  end

  // Flatten the registered field onto the drawer-facing buses.
  always_comb begin
    rows_valid = {ROWS{1'b0}};
    rows_lane  = {(ROWS*LANE_W){1'b0}};
    for (int r = 0; r < ROWS; r++) begin
      rows_valid[r]                 = row_r[r].valid;
      rows_lane[r*LANE_W +: LANE_W] = row_r[r].lane[LANE_W-1:0];
    end
  end

  assign state      = state_r;
  assign game_over  = (state_r == ST_OVER);
  assign score      = score_r;
  assign lives_left = lives_r;
  assign hit_pulse  = hit_r;
  assign miss_pulse = miss_r;

endmodule

// File: tb/tb_tile_lane_engine.sv
// Scoreboard bench for tile_lane_engine: directed games plus narrow-score and 3-lane instances.
module tb_tile_lane_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, step = 1'b0;
  logic [3:0]  keys = 4'd0;
  logic [6:0]  rows_valid;
  logic [13:0] rows_lane;
  logic [15:0] score;
  logic [3:0]  lives_left;
  logic [1:0]  state;
  logic        game_over, hit_pulse, miss_pulse;

  logic [6:0]  rv_s;
  logic [13:0] rl_s;
  logic [2:0]  score_s;
  logic [3:0]  lives_s;
  logic [1:0]  state_s;
  logic        go_s, hit_s, miss_s;

  logic        start_l = 1'b0, step_l = 1'b0;
  logic [2:0]  keys_l = 3'd0;
  logic [6:0]  rv_l;
  logic [13:0] rl_l;
  logic [15:0] score_l;
  logic [3:0]  lives_l;
  logic [1:0]  state_l;
  logic        go_l, hit_l, miss_l;

  typedef struct { bit hit; bit miss; int score; int lives; } ev_t;
  ev_t sbq[$];
  int  n_tests = 0, n_fail = 0;
  logic [15:0] lm;
  int  ml[7];

  always #5 clk = ~clk;

  tile_lane_engine dut (
    .clock(clk), .reset(reset), .start(start), .step(step), .keys(keys),
    .rows_valid(rows_valid), .rows_lane(rows_lane), .score(score), .lives_left(lives_left),
    .state(state), .game_over(game_over), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse));

  tile_lane_engine #(.SCORE_W(3)) dut_s (
    .clock(clk), .reset(reset), .start(start), .step(step), .keys(keys),
    .rows_valid(rv_s), .rows_lane(rl_s), .score(score_s), .lives_left(lives_s),
    .state(state_s), .game_over(go_s), .hit_pulse(hit_s), .miss_pulse(miss_s));

  tile_lane_engine #(.LANES(3)) dut_l (
    .clock(clk), .reset(reset), .start(start_l), .step(step_l), .keys(keys_l),
    .rows_valid(rv_l), .rows_lane(rl_l), .score(score_l), .lives_left(lives_l),
    .state(state_l), .game_over(go_l), .hit_pulse(hit_l), .miss_pulse(miss_l));

  // Reference LFSR, written from the tap list, used only to know where tiles land.
  always @(posedge clk) begin
    if (reset) lm <= 16'hACE1;
    else       lm <= {lm[0] ^ lm[2] ^ lm[3] ^ lm[5], lm[15:1]};
  end

  // Monitor: every hit/miss pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && (hit_pulse || miss_pulse)) begin
      n_tests++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: hit=%0b miss=%0b score=%0d lives=%0d, none expected",
                 hit_pulse, miss_pulse, score, lives_left);
      end else begin
        ev_t e;
        e = sbq.pop_front();
        if (hit_pulse !== e.hit || miss_pulse !== e.miss ||
            int'(score) != e.score || int'(lives_left) != e.lives) begin
          n_fail++;
          $display("FAIL event: got hit=%0b miss=%0b score=%0d lives=%0d, expected hit=%0b miss=%0b score=%0d lives=%0d",
                   hit_pulse, miss_pulse, score, lives_left, e.hit, e.miss, e.score, e.lives);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input bit h, input bit m, input int sc, input int lv);
    ev_t e;
    e.hit = h; e.miss = m; e.score = sc; e.lives = lv;
    sbq.push_back(e);
  endtask

  function automatic logic [3:0] oh(input int l);
    logic [3:0] one;
    one = 4'b0001;
    return one << l;
  endfunction

  // Bench-side field of lanes, advanced just before the edge that samples step.
  task automatic step_field();
    for (int r = 6; r >= 1; r--) ml[r] = ml[r-1];
    ml[0] = int'(lm[7:0]) % 4;
  endtask

  task automatic do_step();
    step_field();
    step = 1'b1; tick(); step = 1'b0;
  endtask

  task automatic do_start(input int exp_score_chk);
    start = 1'b1; tick(); start = 1'b0;
    for (int r = 0; r < 7; r++) ml[r] = 0;
    chk("start_state", state, 1);
    chk("start_rows", rows_valid, 0);
    chk("start_score", score, exp_score_chk);
    chk("start_lives", lives_left, 3);
  endtask

  task automatic fill();
    for (int i = 0; i < 7; i++) do_step();
    chk("fill_rows", rows_valid, 7'h7F);
    chk("fill_bottom_lane", rows_lane[12 +: 2], ml[6]);
  endtask

  initial begin
    logic [3:0] k;
    int bad;
    repeat (3) tick();
    chk("rst_state", state, 0);
    chk("rst_rows", rows_valid, 0);
    chk("rst_lane", rows_lane, 0);
    chk("rst_score", score, 0);
    chk("rst_lives", lives_left, 3);
    reset = 1'b0;

    // Idle: step and keys ignored
    for (int i = 0; i < 6; i++) begin
      step = i[0]; keys = 4'(i + 1); tick();
      chk("idle_rows", rows_valid, 0);
      chk("idle_state", state, 0);
      chk("idle_lives", lives_left, 3);
    end
    step = 1'b0; keys = 4'd0; tick();

    // Game A: fill, overflow miss, hit, wrong lane, double press
    do_start(0);
    fill();
    expect_ev(0, 1, 0, 2); do_step();
    expect_ev(1, 0, 1, 2); keys = oh(ml[6]); tick();
    chk("hit_clears_bottom", rows_valid, 7'h3F);
    tick(); tick();
    keys = 4'd0; tick();
    chk("hold_score", score, 1);
    do_step();
    chk("refill_rows", rows_valid, 7'h7F);
    expect_ev(0, 1, 1, 1); keys = oh((ml[6] + 1) % 4); tick();
    chk("wrong_rows_kept", rows_valid, 7'h7F);
    keys = 4'd0; tick();
    expect_ev(0, 1, 1, 0); keys = oh(ml[6]) | oh((ml[6] + 1) % 4); tick();
    keys = 4'd0; tick(); tick();
    chk("a_over_state", state, 2);
    chk("a_game_over", game_over, 1);
    step = 1'b1; keys = 4'hF; tick(); step = 1'b0; keys = 4'd0; tick();
    chk("over_rows_frozen", rows_valid, 7'h7F);
    chk("over_state_held", state, 2);
    chk("over_lives", lives_left, 0);

    // Game B: same-cycle hit+step, then wrong press + step costing two lives
    do_start(0);
    fill();
    k = oh(ml[6]);
    expect_ev(1, 0, 1, 3); step_field(); keys = k; step = 1'b1; tick();
    step = 1'b0; keys = 4'd0;
    chk("hitstep_rows", rows_valid, 7'h7F);
    tick();
    expect_ev(0, 1, 1, 2); keys = oh((ml[6] + 1) % 4); tick(); keys = 4'd0; tick();
    k = oh((ml[6] + 1) % 4);
    expect_ev(0, 1, 1, 0); step_field(); keys = k; step = 1'b1; tick();
    step = 1'b0; keys = 4'd0;
    chk("double_loss_lives", lives_left, 0);
    tick(); tick();
    chk("b_over_state", state, 2);
    step = 1'b1; tick(); step = 1'b0;
    chk("b_over_step_ignored", rows_valid, 7'h7F);

    // Game C: nine hits, narrow-score instance saturates
    do_start(0);
    chk("s_start_score", score_s, 0);
    fill();
    for (int i = 1; i <= 9; i++) begin
      k = oh(ml[6]);
      expect_ev(1, 0, i, 3); step_field(); keys = k; step = 1'b1; tick();
      step = 1'b0; keys = 4'd0; tick();
    end
    chk("c_score", score, 9);
    chk("c_score_sat", score_s, 7);
    chk("c_lives_s", lives_s, 3);

    // Reset mid-game
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_score", score, 0);
    chk("mid_rst_lives", lives_left, 3);
    chk("mid_rst_rows", rows_valid, 0);

    // Three-lane instance: every lane index stays below 3
    for (int g = 0; g < 20; g++) begin
      start_l = 1'b1; tick(); start_l = 1'b0;
      for (int j = 0; j < 10; j++) begin
        step_l = 1'b1; tick(); step_l = 1'b0;
        bad = 0;
        for (int r = 0; r < 7; r++) if (rl_l[r*2 +: 2] >= 2'd3) bad++;
        chk("lane_range", bad, 0);
      end
      tick(); tick();
    end

    chk("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
